// File: rtl/booth_multiplier_if.sv
// Start/busy/done handshake and operand/product bus for booth_multiplier.
// The master drives the request and operands; the multiplier (slave) returns status and product.
interface booth_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth signed multiplier, WIDTH iterations per product.
// Optional macro BOOTH_ZERO_SKIP_EN: a zero operand finishes in one cycle without entering RUN.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// RUN   | one Booth add/shift iteration per clock, WIDTH in total
// DONE  | product valid, done pulse for one cycle
module booth_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    booth_multiplier_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH:0]       acc;
    logic [WIDTH:0]       mcand;
    logic [WIDTH:0]       neg_mcand;
    logic [WIDTH:0]       a_ext;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       acc_sh;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     q_sh;
    logic                 q_m1;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   product;
    logic                 zero_op;
    logic                 last_iter;

`ifdef BOOTH_ZERO_SKIP_EN
    assign zero_op = (bus.a == '0) || (bus.b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // One extra bit keeps -M exact when M is the most negative operand.
    assign a_ext     = {bus.a[WIDTH-1], bus.a};
    assign last_iter = (cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = zero_op ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc + neg_mcand;
            default: sum = acc;
        endcase
        acc_sh = {sum[WIDTH], sum[WIDTH:1]};
        q_sh   = {sum[0], q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            mcand     <= '0;
            neg_mcand <= '0;
            q         <= '0;
            q_m1      <= 1'b0;
            cnt       <= '0;
            product   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand     <= a_ext;
                        neg_mcand <= ~a_ext + {{WIDTH{1'b0}}, 1'b1};
                        acc       <= '0;
                        q         <= bus.b;
                        q_m1      <= 1'b0;
                        cnt       <= CW'(WIDTH);
                        if (zero_op) begin
                            product <= '0;
                        end
                    end
                end
                RUN: begin
                    acc  <= acc_sh;
                    q    <= q_sh;
                    q_m1 <= q[0];
                    cnt  <= cnt - 1'b1;
                    if (last_iter) begin
                        product <= {acc_sh[WIDTH-1:0], q_sh};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.product = product;
endmodule

// File: tb/tb_booth_multiplier.sv
// Randomized and directed bench for booth_multiplier, checked every cycle against a
// timeline model that derives busy/done/product from accept times and signed arithmetic.
module tb_booth_multiplier;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    booth_multiplier_if #(.WIDTH(W)) bus ();

    booth_multiplier #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edge counter, accept edge, and the resulting output timeline.
    int                     m_edge   = 0;
    int                     m_accept = -1000;
    int                     m_len    = W;
    logic signed [2*W-1:0]  m_pend   = '0;
    logic                   exp_busy = 1'b0;
    logic                   exp_done = 1'b0;
    logic [2*W-1:0]         exp_prod = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_edge   = 0;
            m_accept = -1000;
            m_len    = W;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_prod = '0;
        end else begin
            logic signed [2*W-1:0] sa;
            logic signed [2*W-1:0] sb;
            int d;
            m_edge++;
            if ((m_edge - m_accept >= m_len + 2) && bus.start) begin
                m_accept = m_edge;
                sa = {{W{bus.a[W-1]}}, bus.a};
                sb = {{W{bus.b[W-1]}}, bus.b};
                m_pend = sa * sb;
                m_len = W;
`ifdef BOOTH_ZERO_SKIP_EN
                if (bus.a == '0 || bus.b == '0) m_len = 0;
`endif
            end
            d = m_edge - m_accept;
            exp_busy = (d < m_len);
            exp_done = (d == m_len);
            if (d == m_len) exp_prod = m_pend;
        end
    end

    always @(negedge clk) begin
        check("busy", bus.busy, exp_busy);
        check("done", bus.done, exp_done);
        check("product", bus.product, exp_prod);
        if (bus.done) done_cnt++;
    end

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        v = '0;
        case ($urandom_range(0, 7))
            0: v[W-1] = 1'b1;
            1: v = {1'b0, {(W-1){1'b1}}};
            2: v = '0;
            3: v = '1;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp);
        int n;
        int bc;
        int exp_bc;
        bit got;
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        n = 0;
        bc = 0;
        got = 0;
        while (n < W + 4 && !got) begin
            if (bus.busy) bc++;
            if (bus.done) got = 1;
            else @(negedge clk);
            n++;
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: actual=no_done required=done within %0d cycles", name, W + 4);
        end
        exp_bc = W;
`ifdef BOOTH_ZERO_SKIP_EN
        if (a == '0 || b == '0) exp_bc = 0;
`endif
        check({name, "_product"}, bus.product, exp);
        check({name, "_model"}, exp_prod, exp);
        check({name, "_busy_cycles"}, bc, exp_bc);
        @(negedge clk);
    endtask

    initial begin
        int base;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_product", bus.product, '0);
        rst = 1'b0;
        @(negedge clk);

        run_op("basic_3x5", 8'd3, 8'd5, 16'h000F);
        run_op("neg7x6", 8'hF9, 8'd6, 16'hFFD6);
        run_op("6xneg7", 8'd6, 8'hF9, 16'hFFD6);
        run_op("neg1xneg1", 8'hFF, 8'hFF, 16'h0001);
        run_op("min_x_min", 8'h80, 8'h80, 16'h4000);
        run_op("min_x_max", 8'h80, 8'h7F, 16'hC080);
        run_op("zero_op", 8'h00, 8'h55, 16'h0000);

        // Second requests during RUN and DONE must be ignored.
        base = done_cnt;
        bus.start = 1'b1;
        bus.a = 8'd2;
        bus.b = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'd9;
        bus.b = 8'd9;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < W + 4 && !bus.done; i++) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (W + 4) @(negedge clk);
        #1;
        check("ignored_start_done_count", done_cnt - base, 1);
        check("ignored_start_product", bus.product, 16'h0004);

        // Start held high: accepts every W+2 cycles.
        base = done_cnt;
        bus.start = 1'b1;
        bus.a = 8'd3;
        bus.b = 8'd3;
        repeat (22) @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("held_start_done_count", done_cnt - base, 2);
        repeat (W + 4) @(negedge clk);

        // Asynchronous reset in the 5th RUN cycle abandons the operation.
        bus.start = 1'b1;
        bus.a = 8'd5;
        bus.b = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrun_reset_busy", bus.busy, 1'b0);
        check("midrun_reset_done", bus.done, 1'b0);
        check("midrun_reset_product", bus.product, '0);
        @(negedge clk);
        rst = 1'b0;
        base = done_cnt;
        repeat (W + 4) @(negedge clk);
        #1;
        check("no_done_after_reset", done_cnt - base, 0);
        run_op("after_reset_4x4", 8'd4, 8'd4, 16'h0010);

        // Random traffic, including starts that land in RUN/DONE.
        for (int i = 0; i < 1500; i++) begin
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a = pick_operand();
            bus.b = pick_operand();
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
